// File: rtl/dump_accumulator.sv
// ============================================================================
//  Module   : dump_accumulator
//  Brief    : Integrate-and-dump decimator with streaming handshakes; optional
//             output saturation via DUMP_ACCUMULATOR_SAT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dump_accumulator #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic [15:0]          len,
    input  logic [5:0]           shift,
    input  logic [WIDTH-1:0]     i_tdata,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [OUT_WIDTH-1:0] o_tdata,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic                 o_sat
);

    localparam logic [6:0] c_acc_w = 7'(ACC_WIDTH);

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [15:0]                 r_count;
    logic [15:0]                 r_len_q;
    logic [OUT_WIDTH-1:0]        r_out_q;
    logic                        r_o_tvalid;
    logic                        r_sat;

    logic [15:0]                 w_len_eff;
    logic [15:0]                 w_len_cur;
    logic                        w_first;
    logic                        w_last_pending;
    logic                        w_accept;
    logic signed [ACC_WIDTH-1:0] w_sample_ext;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] w_shifted;
    logic [OUT_WIDTH-1:0]        w_dump;
    logic                        w_dump_sat;

    assign w_len_eff      = (len == 16'd0) ? 16'd1 : len;
    assign w_first        = (r_count == 16'd0);
    // The first beat of a window is judged against the live len, later beats against the latched one.
    assign w_len_cur      = w_first ? w_len_eff : r_len_q;
    assign w_last_pending = (r_count == w_len_cur - 16'd1);

    assign i_tready = reset_n & (~w_last_pending | ~r_o_tvalid | o_tready);
    assign w_accept = i_tvalid & i_tready;

    assign w_sample_ext = ACC_WIDTH'(signed'(i_tdata));
    assign w_sum        = r_acc + w_sample_ext;
    assign w_shifted    = ({1'b0, shift} >= c_acc_w) ? {ACC_WIDTH{w_sum[ACC_WIDTH-1]}}
                                                     : (w_sum >>> shift);

`ifdef DUMP_ACCUMULATOR_SAT_EN
    localparam logic [OUT_WIDTH-1:0] c_out_min = OUT_WIDTH'(1) << (OUT_WIDTH - 1);
    localparam logic [OUT_WIDTH-1:0] c_out_max = ~c_out_min;

    logic [ACC_WIDTH-OUT_WIDTH:0] w_hi;
    logic                         w_ovf;

    // In range only when every bit above the output sign bit matches it.
    assign w_hi       = w_shifted[ACC_WIDTH-1:OUT_WIDTH-1];
    assign w_ovf      = ~((&w_hi) | ~(|w_hi));
    assign w_dump     = w_ovf ? (w_shifted[ACC_WIDTH-1] ? c_out_min : c_out_max)
                              : w_shifted[OUT_WIDTH-1:0];
    assign w_dump_sat = w_ovf;
`else
    logic w_unused_hi;

    assign w_unused_hi = &{1'b0, w_shifted};
    assign w_dump      = w_shifted[OUT_WIDTH-1:0];
    assign w_dump_sat  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc      <= '0;
            r_count    <= 16'd0;
            r_len_q    <= 16'd1;
            r_out_q    <= '0;
            r_o_tvalid <= 1'b0;
            r_sat      <= 1'b0;
        end else if (clear) begin
            r_acc      <= '0;
            r_count    <= 16'd0;
            r_o_tvalid <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_first) begin
                    r_len_q <= w_len_eff;
                end
                if (w_last_pending) begin
                    r_out_q <= w_dump;
                    r_sat   <= w_dump_sat;
                    r_acc   <= '0;
                    r_count <= 16'd0;
                end else begin
                    r_acc   <= w_sum;
                    r_count <= r_count + 16'd1;
                end
            end
            if (w_accept && w_last_pending) begin
                r_o_tvalid <= 1'b1;
            end else if (r_o_tvalid && o_tready) begin
                r_o_tvalid <= 1'b0;
            end
        end
    end

    assign o_tdata  = r_out_q;
    assign o_tvalid = r_o_tvalid;
    assign o_sat    = r_sat;

endmodule

`default_nettype wire
